// File: rtl/text_pkg.sv
// text_pkg: shared constants and state type for the text console writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_pkg;

  localparam int         COLS       = 32;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SCR_RD,
    ST_SCR_HOLD,
    ST_SCR_WR,
    ST_FILL
  } state_e;

endpackage : text_pkg

// File: rtl/text_console.sv
// text_console: byte-stream text writer owning the write port of the 32-column text RAM.
// Latency: accepted byte -> RAM write visible the next cycle; cursor updates on the accept edge.
// Backpressure: in_ready only in IDLE; clear (ROWS*32 cycles) and scroll (96*(ROWS-1)+32) stall input.
// Ports: CLOCK/RESET_N; in_data/in_valid/in_ready byte stream; ram_addr/ram_wdata/ram_we/ram_rdata
//        text RAM port ({row,col} addressing, 1-cycle read latency); cur_col/cur_row cursor; busy.
module text_console
  import text_pkg::*;
#(
  parameter int ROWS = 30
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  input  logic [7:0] ram_rdata,
  output logic [4:0] cur_col,
  output logic [4:0] cur_row,
  output logic       busy
);

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] SCR_LAST = 5'(ROWS - 2);

  state_e     state_q, state_d;
  logic [4:0] cur_col_q, cur_col_d;
  logic [4:0] cur_row_q, cur_row_d;
  // Shared cell pointer for clear, scroll copy (destination row) and fill.
  // It is always back at (0,0) whenever the FSM sits in IDLE.
  logic [4:0] ptr_col_q, ptr_col_d;
  logic [4:0] ptr_row_q, ptr_row_d;
  logic [9:0] addr_q, addr_d;
  // During scroll the write-data register doubles as the read-hold register.
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       row_adv;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_CLEAR;
      cur_col_q <= '0;
      cur_row_q <= '0;
      ptr_col_q <= '0;
      ptr_row_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      ptr_col_q <= ptr_col_d;
      ptr_row_q <= ptr_row_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    ptr_col_d = ptr_col_q;
    ptr_row_d = ptr_row_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    row_adv   = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        addr_d    = {ptr_row_q, ptr_col_q};
        wdata_d   = CHAR_SPACE;
        we_d      = 1'b1;
        ptr_col_d = ptr_col_q + 5'd1;
        if (ptr_col_q == LAST_COL) begin
          ptr_row_d = ptr_row_q + 5'd1;
          if (ptr_row_q == LAST_ROW) begin
            ptr_row_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        if (in_valid) begin
          if (in_data >= CHAR_SPACE) begin
            addr_d    = {cur_row_q, cur_col_q};
            wdata_d   = in_data;
            we_d      = 1'b1;
            cur_col_d = cur_col_q + 5'd1;
            row_adv   = (cur_col_q == LAST_COL);
          end else begin
            unique case (in_data)
              CC_BS: if (cur_col_q != 5'd0) cur_col_d = cur_col_q - 5'd1;
              CC_CR: cur_col_d = '0;
              CC_LF: begin
                cur_col_d = '0;
                row_adv   = 1'b1;
              end
              CC_FF: begin
                cur_col_d = '0;
                cur_row_d = '0;
                state_d   = ST_CLEAR;
              end
              default: ;
            endcase
          end
          if (row_adv) begin
            if (cur_row_q != LAST_ROW) cur_row_d = cur_row_q + 5'd1;
            else                       state_d   = ST_SCR_RD;
          end
        end
      end

      ST_SCR_RD: begin
        addr_d  = {ptr_row_q + 5'd1, ptr_col_q};
        state_d = ST_SCR_HOLD;
      end

      // Read address stays on the bus while the RAM returns the data.
      ST_SCR_HOLD: state_d = ST_SCR_WR;

      ST_SCR_WR: begin
        addr_d    = {ptr_row_q, ptr_col_q};
        wdata_d   = ram_rdata;
        we_d      = 1'b1;
        ptr_col_d = ptr_col_q + 5'd1;
        state_d   = ST_SCR_RD;
        if (ptr_col_q == LAST_COL) begin
          if (ptr_row_q == SCR_LAST) begin
            ptr_row_d = '0;
            state_d   = ST_FILL;
          end else begin
            ptr_row_d = ptr_row_q + 5'd1;
          end
        end
      end

      ST_FILL: begin
        addr_d    = {LAST_ROW, ptr_col_q};
        wdata_d   = CHAR_SPACE;
        we_d      = 1'b1;
        ptr_col_d = ptr_col_q + 5'd1;
        if (ptr_col_q == LAST_COL) state_d = ST_IDLE;
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign cur_col   = cur_col_q;
  assign cur_row   = cur_row_q;

endmodule : text_console
